// File: rtl/conv_row_assembler.sv
// conv_row_assembler: assembles row-buffer words into a padded line with slab carry-over,
// then commits the finished line to the PE-array input register.
module conv_row_assembler #(
    parameter int pixels_in_row = 32,
    parameter int pixel_width   = 8,
    parameter int reg_len       = 48
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 valid_adr,
    input  logic [15:0]                          row_start_idx,
    input  logic [15:0]                          reg_start_idx,
    input  logic [15:0]                          reg_end_idx,
    input  logic [3:0]                           west_pad,
    input  logic [3:0]                           slab_num,
    input  logic [3:0]                           east_pad,
    input  logic                                 conv_pixels_add_end,
    output logic                                 rd_en,
    output logic [15:0]                          rd_adr,
    input  logic [pixels_in_row*pixel_width-1:0] rd_data,
    output logic [reg_len*pixel_width-1:0]       line_data,
    output logic [15:0]                          line_len,
    output logic                                 line_valid,
    output logic                                 err
);
    localparam int lw = $clog2(pixels_in_row);
    localparam int aw = $clog2(reg_len);
    localparam logic [15:0] len16 = 16'(reg_len);
    localparam logic [15:0] pir16 = 16'(pixels_in_row);
    typedef logic [pixel_width-1:0] px_t;

    logic s_valid, s_last, first_flag;
    logic [15:0] s_start, s_end, s_west, s_slab, s_east;
    px_t [reg_len-1:0] work, nxt, commit_line, line_q;
    px_t [pixels_in_row-1:0] rd_px;
    logic [15:0] cnt, data_hi, pos, lane, src;
    logic bad_east, desc_err, data_ok;

    assign rd_en     = reset & valid_adr;
    assign rd_adr    = reset ? row_start_idx : '0;
    assign rd_px     = rd_data;
    assign line_data = line_q;

    // Later writes take priority: row-first fill, then data lanes, then east padding.
    always_comb begin
        data_hi     = s_end - s_east;
        cnt         = data_hi - s_start + 16'd1;
        bad_east    = s_east > s_end - s_start + 16'd1;
        desc_err    = s_start == '0 || s_end > len16 || bad_east || cnt > pir16;
        data_ok     = !bad_east && s_east <= s_end;
        nxt         = work;
        commit_line = '0;
        pos         = '0;
        lane        = '0;
        src         = '0;
        for (int i = 0; i < reg_len; i++) begin
            pos  = 16'(i + 1);
            lane = pos - s_start;
            src  = line_len - s_slab + pos - s_west;
            if (first_flag && pos <= s_west)
                nxt[i] = '0;
            else if (first_flag && pos <= s_west + s_slab)
                nxt[i] = (src >= 16'd1 && src <= len16) ? line_q[aw'(src - 16'd1)] : '0;
            if (data_ok && pos >= s_start && pos <= data_hi && lane < pir16)
                nxt[i] = rd_px[lw'(lane)];
            if (data_ok && pos > data_hi && pos <= s_end)
                nxt[i] = '0;
            commit_line[i] = pos <= s_end ? nxt[i] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_valid    <= 1'b0;
            s_last     <= 1'b0;
            s_start    <= '0;
            s_end      <= '0;
            s_west     <= '0;
            s_slab     <= '0;
            s_east     <= '0;
            work       <= '0;
            line_q     <= '0;
            line_len   <= '0;
            line_valid <= 1'b0;
            err        <= 1'b0;
            first_flag <= 1'b1;
        end else begin
            s_valid    <= valid_adr;
            s_last     <= conv_pixels_add_end;
            s_start    <= reg_start_idx;
            s_end      <= reg_end_idx;
            s_west     <= 16'(west_pad);
            s_slab     <= 16'(slab_num);
            s_east     <= 16'(east_pad);
            line_valid <= s_valid && s_last;
            err        <= err || (s_valid && desc_err);
            if (s_valid) begin
                work       <= s_last ? '0 : nxt;
                first_flag <= s_last;
                if (s_last) begin
                    line_q   <= commit_line;
                    line_len <= s_end;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_row_assembler.sv
// tb_conv_row_assembler: directed scenarios with hand-computed expected lines.
module tb_conv_row_assembler;
    logic         clk = 1'b0, reset = 1'b0;
    logic         valid_adr = 1'b0, conv_pixels_add_end = 1'b0;
    logic [15:0]  row_start_idx = '0, reg_start_idx = '0, reg_end_idx = '0;
    logic [3:0]   west_pad = '0, slab_num = '0, east_pad = '0;
    logic [255:0] rd_data = '0;
    logic         rd_en, line_valid, err;
    logic [15:0]  rd_adr, line_len;
    logic [383:0] line_data, exp_line;
    int checks = 0, failures = 0;

    conv_row_assembler dut (
        .clk(clk), .reset(reset), .valid_adr(valid_adr),
        .row_start_idx(row_start_idx), .reg_start_idx(reg_start_idx), .reg_end_idx(reg_end_idx),
        .west_pad(west_pad), .slab_num(slab_num), .east_pad(east_pad),
        .conv_pixels_add_end(conv_pixels_add_end),
        .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data),
        .line_data(line_data), .line_len(line_len), .line_valid(line_valid), .err(err)
    );

    always #5 clk = ~clk;

    task desc(input logic [3:0] w, input logic [3:0] s, input logic [15:0] st,
              input logic [15:0] en, input logic [3:0] e, input logic l, input logic [15:0] row);
        valid_adr = 1'b1; west_pad = w; slab_num = s; reg_start_idx = st;
        reg_end_idx = en; east_pad = e; conv_pixels_add_end = l; row_start_idx = row;
    endtask

    task idle();
        valid_adr = 1'b0;
        conv_pixels_add_end = 1'b0;
    endtask

    task set_rd(input int base);
        for (int i = 0; i < 32; i++) rd_data[i*8 +: 8] = 8'(base + i);
    endtask

    task set_exp(input int p0, input int p1, input int base);
        for (int p = p0; p <= p1; p++) exp_line[(p-1)*8 +: 8] = 8'(base + p - p0);
    endtask

    task test_reset();
        valid_adr = 1'b1; row_start_idx = 16'd5;
        #2;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
        checks++; if (rd_adr !== 16'd0) begin failures++; $display("FAIL reset_rd_adr got=%0d want=0", rd_adr); end
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL reset_line_valid got=%b want=0", line_valid); end
        checks++; if (line_len !== 16'd0) begin failures++; $display("FAIL reset_line_len got=%0d want=0", line_len); end
        checks++; if (line_data !== '0) begin failures++; $display("FAIL reset_line_data got=%h want=0", line_data); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        idle();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL post_reset_err got=%b want=0", err); end
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b want=0", line_valid); end
    endtask

    task test_single();
        @(negedge clk); desc(1, 0, 2, 18, 1, 1, 0);
        #1;
        checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL single_rd_en got=%b want=1", rd_en); end
        checks++; if (rd_adr !== 16'd0) begin failures++; $display("FAIL single_rd_adr got=%0d want=0", rd_adr); end
        @(negedge clk); idle(); set_rd(1);
        #1;
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b want=0", line_valid); end
        exp_line = '0; set_exp(2, 17, 1);
        @(negedge clk);
        checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b want=1", line_valid); end
        checks++; if (line_data !== exp_line) begin failures++; $display("FAIL single_data got=%h want=%h", line_data, exp_line); end
        checks++; if (line_len !== 16'd18) begin failures++; $display("FAIL single_len got=%0d want=18", line_len); end
        @(negedge clk);
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b want=0", line_valid); end
    endtask

    task test_back_to_back();
        @(negedge clk); desc(1, 0, 2, 33, 0, 0, 0);
        @(negedge clk); desc(0, 0, 34, 42, 1, 1, 32); set_rd(1);
        #1;
        checks++; if (rd_adr !== 16'd32) begin failures++; $display("FAIL b2b_rd_adr got=%0d want=32", rd_adr); end
        @(negedge clk); idle(); set_rd(100);
        #1;
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL b2b_early_valid got=%b want=0", line_valid); end
        exp_line = '0; set_exp(2, 33, 1); set_exp(34, 41, 100);
        @(negedge clk);
        checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b want=1", line_valid); end
        checks++; if (line_data !== exp_line) begin failures++; $display("FAIL b2b_data got=%h want=%h", line_data, exp_line); end
        checks++; if (line_len !== 16'd42) begin failures++; $display("FAIL b2b_len got=%0d want=42", line_len); end
        @(negedge clk);
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse got=%b want=0", line_valid); end
    endtask

    task test_slab();
        @(negedge clk); desc(0, 2, 3, 10, 0, 1, 0);
        @(negedge clk); idle(); set_rd(50);
        exp_line = '0; exp_line[7:0] = 8'd107; set_exp(3, 10, 50);
        @(negedge clk);
        checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL slab_valid got=%b want=1", line_valid); end
        checks++; if (line_data !== exp_line) begin failures++; $display("FAIL slab_data got=%h want=%h", line_data, exp_line); end
        checks++; if (line_len !== 16'd10) begin failures++; $display("FAIL slab_len got=%0d want=10", line_len); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL slab_err got=%b want=0", err); end
    endtask

    task test_abort();
        @(negedge clk); desc(0, 0, 1, 32, 0, 0, 0);
        @(negedge clk); set_rd(1); reset = 1'b0; row_start_idx = 16'd7;
        #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL abort_rd_en got=%b want=0", rd_en); end
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b want=0", line_valid); end
        checks++; if (line_len !== 16'd0) begin failures++; $display("FAIL abort_len got=%0d want=0", line_len); end
        checks++; if (line_data !== '0) begin failures++; $display("FAIL abort_data got=%h want=0", line_data); end
        @(negedge clk); idle(); reset = 1'b1;
        #1;
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL abort_release_valid got=%b want=0", line_valid); end
        @(negedge clk); desc(0, 1, 2, 5, 0, 1, 0);
        @(negedge clk); idle(); set_rd(10);
        #1;
        checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL abort_early_valid got=%b want=0", line_valid); end
        exp_line = '0; set_exp(2, 5, 10);
        @(negedge clk);
        checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL abort_new_valid got=%b want=1", line_valid); end
        checks++; if (line_data !== exp_line) begin failures++; $display("FAIL abort_new_data got=%h want=%h", line_data, exp_line); end
        checks++; if (line_len !== 16'd5) begin failures++; $display("FAIL abort_new_len got=%0d want=5", line_len); end
    endtask

    task test_error();
        @(negedge clk); desc(0, 0, 20, 50, 0, 1, 0);
        @(negedge clk); idle(); set_rd(1);
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_early got=%b want=0", err); end
        exp_line = '0; set_exp(20, 48, 1);
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", err); end
        checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL err_valid got=%b want=1", line_valid); end
        checks++; if (line_data !== exp_line) begin failures++; $display("FAIL err_data got=%h want=%h", line_data, exp_line); end
        checks++; if (line_len !== 16'd50) begin failures++; $display("FAIL err_len got=%0d want=50", line_len); end
        @(negedge clk); desc(0, 0, 1, 4, 0, 1, 0);
        @(negedge clk); idle();
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err); end
        checks++; if (line_len !== 16'd4) begin failures++; $display("FAIL err_next_len got=%0d want=4", line_len); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_slab();
        test_abort();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_row_assembler.md
# conv_row_assembler

Receive side of the conv row-address descriptor stream. For every descriptor (valid_adr pulse) it issues one row-buffer read at row_start_idx. It then writes the returned pixels_in_row-pixel word into a working line register at positions reg_start_idx..reg_end_idx. West/east padding is zero-filled and slab_num overlap pixels are carried over from the previous line. On the descriptor flagged conv_pixels_add_end it commits the assembled line to the PE-array input register and pulses line_valid.

## Interface
- pixels_in_row, 32, pixels per row-buffer read word
- pixel_width, 8, bits per pixel
- reg_len, 48, line register positions (1-based, positions 1..reg_len)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_adr  in  1  descriptor valid, one per cycle max, no backpressure
- row_start_idx  in  16  pixel address of first pixel of this word
- reg_start_idx  in  16  first line position written from rd_data
- reg_end_idx  in  16  last line position touched, includes east_pad
- west_pad  in  4  zero positions before data (row-first descriptor only)
- slab_num  in  4  overlap positions carried from previous line (row-first only)
- east_pad  in  4  zero positions after data (last descriptor only)
- conv_pixels_add_end  in  1  marks last descriptor of the row
- rd_en  out  1  row-buffer read strobe
- rd_adr  out  16  row-buffer pixel address
- rd_data  in  pixels_in_row*pixel_width  read data, lane 0 = pixel at rd_adr, valid 1 cycle after rd_en
- line_data  out  reg_len*pixel_width  committed line, position n at lane n-1
- line_len  out  16  last valid position of committed line
- line_valid  out  1  one-cycle pulse, line_data/line_len updated
- err  out  1  sticky descriptor error

## Operation
- Stage 0 (combinational): rd_en = valid_adr, rd_adr = row_start_idx. The descriptor fields are registered into stage 1.
- Stage 1 (one cycle later): cnt = reg_end_idx - east_pad - reg_start_idx + 1.
  - Positions reg_start_idx..reg_start_idx+cnt-1 receive rd_data lanes 0..cnt-1.
  - Positions reg_end_idx-east_pad+1..reg_end_idx are written 0.
- first_flag is set by reset and after every commit, and cleared after the next stage-1 write. When it is set:
  - positions 1..west_pad are written 0;
  - positions west_pad+1..west_pad+slab_num receive committed line_data positions line_len-slab_num+1..line_len. If no line has been committed yet, they receive 0.
- Commit happens when stage 1 holds a conv_pixels_add_end descriptor:
  - line_data <= working register including this cycle's writes, with positions > reg_end_idx forced to 0;
  - line_len <= reg_end_idx;
  - working register is cleared to 0.
- Error conditions, which set err and keep it set until reset:
  - reg_start_idx == 0;
  - reg_end_idx > reg_len;
  - cnt > pixels_in_row;
  - east_pad > reg_end_idx - reg_start_idx + 1.
- Error handling: out-of-range positions are discarded and in-range writes still occur.
- Width rules: all index arithmetic is 16-bit unsigned. cnt is evaluated only when err is not raised by the same descriptor.

## Timing
- Reset values (async, immediate): rd_en=0, rd_adr=0, line_valid=0, line_len=0, line_data=0, err=0, working register=0, first_flag=1, stage-1 valid=0.
- Descriptor at cycle T:
  - rd_en/rd_adr in cycle T;
  - rd_data sampled and working register written at the end of T+1;
  - if last, line_valid=1 and new line_data in T+2.
- Back-to-back: descriptors are accepted every cycle; throughput is 1 word/cycle. No stall and no handshake; the producer's own stalls simply produce idle cycles.
- Simultaneous events: a row-N last at T followed by a row-N+1 first at T+1 is legal. Slab data is taken from the line committed at the end of T+1 and is valid for the T+2 stage-1 write.
- line_valid never asserts on consecutive cycles unless last descriptors arrive on consecutive cycles.
- Reset mid-row: in-flight descriptor and partial working line are discarded. The next descriptor is treated as row-first with slab source 0. No line_valid is produced for the aborted row.

## Test plan
- Reset: drive reset=0 during activity -> all outputs 0 immediately. After release, err=0 and line_valid=0 until the first last-descriptor.
- Single-word row: at T drive west_pad=1, slab_num=0, reg_start_idx=2, reg_end_idx=18, east_pad=1, conv_pixels_add_end=1, row_start_idx=0, with rd_data lane i = i+1 at T+1. Expected: rd_en=1, rd_adr=0 at T; line_valid at T+2; pos1=0, pos2..17=1..16, pos18..48=0; line_len=18.
- Two-word row, back-to-back:
  - first descriptor: reg_start_idx 2, reg_end_idx 33, west_pad 1, rd_data lane i = i+1;
  - second descriptor, next cycle: reg_start_idx 34, reg_end_idx 42, east_pad 1, last, rd_data lane i = i+100;
  - expected: pos2..33=1..32, pos34..41=100..107, pos42=0, line_len=42, one line_valid pulse.
- Slab carry: after the previous scenario, send a last descriptor with slab_num=2, west_pad=0, reg_start_idx=3, reg_end_idx=10. Expected: pos1=107, pos2=0 (previous pos41..42), pos3..10 from rd_data.
- Error: reg_end_idx=50, reg_start_idx=20, east_pad=0, last. Expected: err=1 and stays 1; positions 20..48 written from lanes 0..28; line_len=50.
- Abort: first descriptor of a row, then reset pulse, then a last descriptor with slab_num=1. Expected: no line_valid for the aborted row; pos1 of the new line = 0.
